data_ram_responder: RTL



---
 rtl/mem_pkg.sv | 23 ++
 rtl/data_ram_array.sv | 33 +++
 rtl/data_ram_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// mem_pkg : shared encodings and default sizes for the data memory path
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int CNT_WIDTH          = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/data_ram_array.sv
//------------------------------------------------------------------------------
// data_ram_array : single-port storage, synchronous write, combinational read
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_ram_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // The responder registers this value into RAM_out on the completion edge.
    assign rdata = mem_q[addr];

endmodule

`default_nettype wire

// File: rtl/data_ram_responder.sv
//------------------------------------------------------------------------------
// data_ram_responder : wait-state request/ready front end for the data RAM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_ram_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  RW,
    input  logic [31:0]           address_in,
    input  logic [DATA_WIDTH-1:0] RAM_in,
    output logic [DATA_WIDTH-1:0] RAM_out,
    output logic                  ready,
    output logic                  busy,
    output logic                  addr_err
);

    state_e                 state_q,    state_d;
    logic [CNT_WIDTH-1:0]   cnt_q,      cnt_d;
    logic                   rw_q,       rw_d;
    logic [31:0]            addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q,    wdata_d;
    logic [DATA_WIDTH-1:0]  ram_out_q,  ram_out_d;
    logic                   ready_q,    ready_d;
    logic                   addr_err_q, addr_err_d;

    logic                   mem_we;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   out_of_range;

    assign out_of_range = |(addr_q >> ADDR_WIDTH);

    data_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q[ADDR_WIDTH-1:0]),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ram_out_d  = ram_out_q;
        ready_d    = 1'b0;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    rw_d    = RW;
                    addr_d  = address_in;
                    wdata_d = RAM_in;
                    cnt_d   = CNT_WIDTH'(WAIT_STATES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ready_d    = 1'b1;
                    addr_err_d = out_of_range;
                    state_d    = IDLE;
                    if (rw_q == RW_READ) begin
                        ram_out_d = out_of_range ? '0 : mem_rdata;
                    end else begin
                        // Out-of-range writes are dropped rather than aliased.
                        mem_we = !out_of_range;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rw_q       <= RW_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            ram_out_q  <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ram_out_q  <= ram_out_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign RAM_out  = ram_out_q;
    assign ready    = ready_q;
    assign addr_err = addr_err_q;
    assign busy     = (state_q == BUSY);

endmodule

`default_nettype wire
